// File: rtl/flexpiso_pkg.sv
// Shared types, default sizes and the frame-length clamp for the flexpiso_stream slice.
package flexpiso_pkg;

    localparam int FP_WIDTH  = 16;
    localparam int FP_DEPTH  = 12;
    localparam int FP_NUM_CH = 2;
    localparam int FP_LW     = $clog2(FP_DEPTH) + 1;

    typedef logic signed [FP_WIDTH-1:0] sample_t;
    typedef sample_t lane_t [FP_NUM_CH];

    function automatic int clamp_len(input int len, input int depth);
        return (len > depth) ? depth : len;
    endfunction

endpackage

// File: rtl/flexpiso_bank.sv
// One ping-pong storage bank: whole-frame write, stored length/prefix, and a beat-indexed read mux.
module flexpiso_bank
    import flexpiso_pkg::*;
#(
    parameter int WIDTH  = FP_WIDTH,
    parameter int DEPTH  = FP_DEPTH,
    parameter int NUM_CH = FP_NUM_CH,
    parameter int LW     = $clog2(DEPTH) + 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_we,
    input  logic signed [WIDTH-1:0] i_pin [0:DEPTH-1][0:NUM_CH-1],
    input  logic [LW-1:0]           i_lim,
    input  logic [LW-1:0]           i_cp,
    input  logic [LW-1:0]           i_beat,
    output logic [LW-1:0]           o_lim,
    output logic [LW-1:0]           o_cp,
    output logic signed [WIDTH-1:0] o_data [0:NUM_CH-1]
);

    logic signed [WIDTH-1:0] mem [0:DEPTH-1][0:NUM_CH-1];
    logic [LW-1:0]           lim_q;
    logic [LW-1:0]           cp_q;
    logic [LW-1:0]           idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lim_q <= '0;
            cp_q  <= '0;
        end else if (i_we) begin
            lim_q <= i_lim;
            cp_q  <= i_cp;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int d = 0; d < DEPTH; d++) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    mem[d][c] <= i_pin[d][c];
                end
            end
        end
    end

    // Prefix beats replay the tail of the frame, body beats start from index 0.
    assign idx = (i_beat < cp_q) ? (lim_q - cp_q + i_beat) : (i_beat - cp_q);

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            o_data[c] = '0;
        end
        for (int d = 0; d < DEPTH; d++) begin
            if (idx == LW'(d)) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    o_data[c] = mem[d][c];
                end
            end
        end
    end

    assign o_lim = lim_q;
    assign o_cp  = cp_q;

endmodule

// File: rtl/flexpiso_stream.sv
// Double-buffered multi-lane parallel-in/serial-out framer with valid/ready output.
// Define FLEXPISO_CP_EN to add a per-frame cyclic prefix (i_cp_len in, o_cp out).
module flexpiso_stream
    import flexpiso_pkg::*;
#(
    parameter int WIDTH  = FP_WIDTH,
    parameter int DEPTH  = FP_DEPTH,
    parameter int NUM_CH = FP_NUM_CH,
    parameter int LW     = $clog2(DEPTH) + 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    output logic                    o_load_rdy,
    input  logic signed [WIDTH-1:0] i_pin [0:DEPTH-1][0:NUM_CH-1],
    input  logic [LW-1:0]           i_limit,
`ifdef FLEXPISO_CP_EN
    input  logic [LW-1:0]           i_cp_len,
    output logic                    o_cp,
`endif
    output logic signed [WIDTH-1:0] o_sout [0:NUM_CH-1],
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_first,
    output logic                    o_last,
    output logic                    o_drop
);

    logic [1:0]              full_q;
    logic                    wr_sel_q;
    logic                    rd_sel_q;
    logic [LW-1:0]           rd_ptr_q;
    logic                    drop_q;

    logic                    load_acc;
    logic                    xfer;
    logic                    release_bank;
    logic [LW-1:0]           lim_in;
    logic [LW-1:0]           cp_in;
    logic [LW-1:0]           lim0, lim1, cp0, cp1;
    logic [LW-1:0]           cur_lim, cur_cp, span;
    logic signed [WIDTH-1:0] data0 [0:NUM_CH-1];
    logic signed [WIDTH-1:0] data1 [0:NUM_CH-1];

    assign lim_in = LW'(clamp_len(int'(i_limit), DEPTH));
`ifdef FLEXPISO_CP_EN
    assign cp_in  = (i_cp_len >= lim_in) ? lim_in - 1'b1 : i_cp_len;
`else
    assign cp_in  = '0;
`endif

    assign o_load_rdy = !i_rst && !full_q[wr_sel_q];
    assign load_acc   = i_load && o_load_rdy && (i_limit != '0);

    flexpiso_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .LW(LW)) u_bank0 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_we   (load_acc && !wr_sel_q),
        .i_pin  (i_pin),
        .i_lim  (lim_in),
        .i_cp   (cp_in),
        .i_beat (rd_ptr_q),
        .o_lim  (lim0),
        .o_cp   (cp0),
        .o_data (data0)
    );

    flexpiso_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .LW(LW)) u_bank1 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_we   (load_acc && wr_sel_q),
        .i_pin  (i_pin),
        .i_lim  (lim_in),
        .i_cp   (cp_in),
        .i_beat (rd_ptr_q),
        .o_lim  (lim1),
        .o_cp   (cp1),
        .o_data (data1)
    );

    // rd_ptr counts beats of the whole frame, prefix included.
    assign cur_lim      = rd_sel_q ? lim1 : lim0;
    assign cur_cp       = rd_sel_q ? cp1  : cp0;
    assign span         = cur_lim + cur_cp;

    assign o_valid      = full_q[rd_sel_q];
    assign o_first      = o_valid && (rd_ptr_q == '0);
    assign o_last       = o_valid && (rd_ptr_q == span - 1'b1);
    assign o_drop       = drop_q;
    assign xfer         = o_valid && i_ready;
    assign release_bank = xfer && o_last;
`ifdef FLEXPISO_CP_EN
    assign o_cp         = o_valid && (rd_ptr_q < cur_cp);
`endif

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            o_sout[c] = '0;
            if (o_valid) begin
                o_sout[c] = rd_sel_q ? data1[c] : data0[c];
            end
        end
    end

    // A load only targets a free bank and a release only a full one, so the two never collide.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            full_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            rd_ptr_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            drop_q <= i_load && !load_acc;
            if (load_acc) begin
                full_q[wr_sel_q] <= 1'b1;
                wr_sel_q         <= ~wr_sel_q;
            end
            if (xfer) begin
                if (release_bank) begin
                    rd_ptr_q         <= '0;
                    full_q[rd_sel_q] <= 1'b0;
                    rd_sel_q         <= ~rd_sel_q;
                end else begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_flexpiso_stream.sv
// Bench for flexpiso_stream: frame-queue reference model with per-cycle compare plus directed literal checks.
module tb_flexpiso_stream;

    localparam int W  = 16;
    localparam int D  = 12;
    localparam int NC = 2;
    localparam int LW = $clog2(D) + 1;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic                i_load;
    logic                o_load_rdy;
    logic signed [W-1:0] i_pin [0:D-1][0:NC-1];
    logic [LW-1:0]       i_limit;
    logic signed [W-1:0] o_sout [0:NC-1];
    logic                o_valid;
    logic                i_ready;
    logic                o_first;
    logic                o_last;
    logic                o_drop;
`ifdef FLEXPISO_CP_EN
    logic [LW-1:0]       i_cp_len;
    logic                o_cp;
`endif

    always #5 i_clk = ~i_clk;

    flexpiso_stream #(.WIDTH(W), .DEPTH(D), .NUM_CH(NC)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (i_load),
        .o_load_rdy (o_load_rdy),
        .i_pin      (i_pin),
        .i_limit    (i_limit),
`ifdef FLEXPISO_CP_EN
        .i_cp_len   (i_cp_len),
        .o_cp       (o_cp),
`endif
        .o_sout     (o_sout),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_first    (o_first),
        .o_last     (o_last),
        .o_drop     (o_drop)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: a queue of expected beats, at most two frames outstanding.
    typedef struct {
        logic signed [W-1:0] s0;
        logic signed [W-1:0] s1;
        bit                  first;
        bit                  last;
        bit                  cp;
    } beat_t;

    beat_t exp_q[$];
    int    nfr      = 0;
    bit    exp_drop = 1'b0;
    bit    live     = 1'b0;

    task automatic push_frame();
        int    len, cpl, idx;
        beat_t e;
        len = (int'(i_limit) > D) ? D : int'(i_limit);
        cpl = 0;
`ifdef FLEXPISO_CP_EN
        cpl = int'(i_cp_len);
        if (cpl >= len) cpl = len - 1;
`endif
        for (int b = 0; b < len + cpl; b++) begin
            idx     = (b < cpl) ? (len - cpl + b) : (b - cpl);
            e.s0    = i_pin[idx][0];
            e.s1    = i_pin[idx][1];
            e.first = (b == 0);
            e.last  = (b == len + cpl - 1);
            e.cp    = (b < cpl);
            exp_q.push_back(e);
        end
    endtask

    always @(posedge i_clk) begin : model
        bit rdy;
        if (i_rst) begin
            exp_q.delete();
            nfr      = 0;
            exp_drop = 1'b0;
            live     = 1'b1;
        end else if (live) begin
            rdy = (nfr < 2);
            if (exp_q.size() > 0 && i_ready) begin
                if (exp_q[0].last) nfr--;
                void'(exp_q.pop_front());
            end
            exp_drop = 1'b0;
            if (i_load) begin
                if (rdy && i_limit != '0) begin
                    push_frame();
                    nfr++;
                end else begin
                    exp_drop = 1'b1;
                end
            end
        end
    end

    logic signed [W-1:0] prev0, prev1;
    bit                  prev_stall = 1'b0;

    always @(negedge i_clk) begin : compare
        bit ev;
        if (live) begin
            ev = (exp_q.size() > 0);
            chk("valid", o_valid, ev);
            chk("load_rdy", o_load_rdy, !i_rst && (nfr < 2));
            chk("drop", o_drop, exp_drop);
            if (ev) begin
                chk("sout0", o_sout[0], exp_q[0].s0);
                chk("sout1", o_sout[1], exp_q[0].s1);
                chk("first", o_first, exp_q[0].first);
                chk("last", o_last, exp_q[0].last);
`ifdef FLEXPISO_CP_EN
                chk("cp", o_cp, exp_q[0].cp);
`endif
            end else begin
                chk("idle_sout0", o_sout[0], '0);
                chk("idle_sout1", o_sout[1], '0);
                chk("idle_first", o_first, 1'b0);
                chk("idle_last", o_last, 1'b0);
            end
            if (prev_stall) begin
                chk("stall_hold0", o_sout[0], prev0);
                chk("stall_hold1", o_sout[1], prev1);
            end
            prev_stall = o_valid && !i_ready && !i_rst;
            prev0      = o_sout[0];
            prev1      = o_sout[1];
        end
    end

    // Directed-test capture of every transferred beat.
    typedef struct {
        logic signed [W-1:0] s0;
        logic signed [W-1:0] s1;
        bit                  first;
        bit                  last;
        bit                  cp;
        int                  cyc;
    } log_t;

    log_t lg[$];
    int   cyc_n = 0;

    task automatic step();
        log_t l;
        @(negedge i_clk);
        if (o_valid && i_ready && !i_rst) begin
            l.s0    = o_sout[0];
            l.s1    = o_sout[1];
            l.first = o_first;
            l.last  = o_last;
            l.cp    = 1'b0;
`ifdef FLEXPISO_CP_EN
            l.cp    = o_cp;
`endif
            l.cyc   = cyc_n;
            lg.push_back(l);
        end
        cyc_n++;
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_ramp(input int base);
        for (int n = 0; n < D; n++) begin
            i_pin[n][0] = W'(base + n);
            i_pin[n][1] = W'(-(base + n));
        end
    endtask

    task automatic load(input int lim, input int cpl);
        i_load  = 1'b1;
        i_limit = LW'(lim);
`ifdef FLEXPISO_CP_EN
        i_cp_len = LW'(cpl);
`else
        if (cpl != 0) $display("note: prefix length ignored in this build");
`endif
        step();
        i_load = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int k;
        k = 0;
        while (o_valid && k < maxc) begin
            step();
            k++;
        end
        chk("drain_done", o_valid, 1'b0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        i_rst   = 1'b1;
        i_load  = 1'b1;
        i_limit = LW'(12);
        i_ready = 1'b1;
`ifdef FLEXPISO_CP_EN
        i_cp_len = '0;
`endif
        set_ramp(0);
        @(posedge i_clk);
        #1;
        step();
        step();
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_load_rdy", o_load_rdy, 1'b0);
        chk("rst_drop", o_drop, 1'b0);
        chk("rst_sout0", o_sout[0], '0);
        i_rst  = 1'b0;
        i_load = 1'b0;
        #1;
        chk("rdy_after_rst", o_load_rdy, 1'b1);
        step();

        // Ramp frame of 12
        lg.delete();
        set_ramp(0);
        load(12, 0);
        chk("lat_valid", o_valid, 1'b1);
        chk("lat_first", o_first, 1'b1);
        chk("lat_sout0", o_sout[0], 32'd0);
        drain(40);
        chk("ramp_count", lg.size(), 12);
        for (int n = 0; n < lg.size(); n++) begin
            chk("ramp_s0", lg[n].s0, 32'(n));
            chk("ramp_s1", lg[n].s1, 32'(-n));
            chk("ramp_first", lg[n].first, (n == 0));
            chk("ramp_last", lg[n].last, (n == 11));
        end

        // Back-to-back frames and a rejected third load
        lg.delete();
        set_ramp(100);
        i_load  = 1'b1;
        i_limit = LW'(12);
        step();
        set_ramp(200);
        i_limit = LW'(5);
        step();
        chk("both_full_rdy", o_load_rdy, 1'b0);
        set_ramp(300);
        i_limit = LW'(3);
        step();
        i_load = 1'b0;
        chk("drop_pulse", o_drop, 1'b1);
        step();
        chk("drop_clear", o_drop, 1'b0);
        drain(40);
        chk("b2b_count", lg.size(), 17);
        for (int n = 0; n < lg.size(); n++) begin
            chk("b2b_s0", lg[n].s0, (n < 12) ? 32'(100 + n) : 32'(200 + n - 12));
            chk("b2b_contig", lg[n].cyc - lg[0].cyc, n);
        end

        // Limit clamp, limit 0, limit 1
        lg.delete();
        set_ramp(0);
        load(20, 0);
        drain(40);
        chk("clamp_count", lg.size(), 12);
        if (lg.size() == 12) begin
            chk("clamp_last_s0", lg[11].s0, 32'd11);
            chk("clamp_last_flag", lg[11].last, 1'b1);
        end
        lg.delete();
        load(0, 0);
        chk("lim0_drop", o_drop, 1'b1);
        chk("lim0_valid", o_valid, 1'b0);
        step();
        chk("lim0_still_idle", o_valid, 1'b0);
        set_ramp(50);
        load(1, 0);
        chk("lim1_first", o_first, 1'b1);
        chk("lim1_last", o_last, 1'b1);
        chk("lim1_sout0", o_sout[0], 32'd50);
        drain(10);
        chk("lim1_count", lg.size(), 1);

        // Random backpressure across two frames
        lg.delete();
        set_ramp(0);
        i_ready = 1'($urandom_range(0, 1));
        i_load  = 1'b1;
        i_limit = LW'(12);
        step();
        set_ramp(500);
        i_limit = LW'(7);
        i_ready = 1'($urandom_range(0, 1));
        step();
        i_load = 1'b0;
        k = 0;
        while (o_valid && k < 300) begin
            i_ready = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        i_ready = 1'b1;
        chk("rand_done", o_valid, 1'b0);
        chk("rand_count", lg.size(), 19);
        for (int n = 0; n < lg.size(); n++) begin
            chk("rand_s0", lg[n].s0, (n < 12) ? 32'(n) : 32'(500 + n - 12));
        end

        // Reset in the middle of a frame with the other bank full
        lg.delete();
        set_ramp(0);
        i_load  = 1'b1;
        i_limit = LW'(12);
        step();
        step();
        i_load = 1'b0;
        k = 0;
        while (lg.size() < 6 && k < 40) begin
            step();
            k++;
        end
        chk("mid_beats", lg.size(), 6);
        i_rst = 1'b1;
        step();
        chk("mid_rst_valid", o_valid, 1'b0);
        chk("mid_rst_rdy", o_load_rdy, 1'b0);
        i_rst = 1'b0;
        step();
        lg.delete();
        set_ramp(700);
        load(4, 0);
        drain(20);
        chk("post_rst_count", lg.size(), 4);
        if (lg.size() > 0) begin
            chk("post_rst_s0", lg[0].s0, 32'd700);
            chk("post_rst_first", lg[0].first, 1'b1);
        end

`ifdef FLEXPISO_CP_EN
        lg.delete();
        set_ramp(0);
        load(12, 3);
        drain(40);
        chk("cp3_count", lg.size(), 15);
        for (int n = 0; n < lg.size(); n++) begin
            chk("cp3_s0", lg[n].s0, (n < 3) ? 32'(9 + n) : 32'(n - 3));
            chk("cp3_flag", lg[n].cp, (n < 3));
        end
        lg.delete();
        load(12, 15);
        drain(40);
        chk("cp15_count", lg.size(), 23);
        if (lg.size() == 23) begin
            chk("cp15_first_s0", lg[0].s0, 32'd1);
            chk("cp15_first_flag", lg[0].first, 1'b1);
            chk("cp15_body0", lg[11].s0, 32'd0);
            chk("cp15_body0_cp", lg[11].cp, 1'b0);
            chk("cp15_last", lg[22].last, 1'b1);
        end
`endif

        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
